// File: rtl/nor_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nor_gate_pkg
//  Purpose  : Shared constants and types for the NOR-lane primitive.
//             - C_DEFAULT_WIDTH : default number of NOR lanes
//             - C_DEFAULT_CNT_W : default width of the statistics counter
//             - hit_cnt_t       : saturating hit counter at default width
//  Revision : 1.0  initial release
// ============================================================================
package nor_gate_pkg;

    localparam int C_DEFAULT_WIDTH = 1;
    localparam int C_DEFAULT_CNT_W = 16;

    // Hit counter at the default counter width; saturates at all-ones.
    typedef logic [C_DEFAULT_CNT_W-1:0] hit_cnt_t;

endpackage : nor_gate_pkg
`default_nettype wire

// File: rtl/nor_lane.sv
`default_nettype none
// ============================================================================
//  Module   : nor_lane
//  Purpose  : Single-bit combinational 2-input NOR.
//  Ports    : a, b - operand bits
//             y    - ~(a | b)
//  Revision : 1.0  initial release
// ============================================================================
module nor_lane (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule : nor_lane
`default_nettype wire

// File: rtl/nor_gate_unit.sv
`default_nettype none
// ============================================================================
//  Module   : nor_gate_unit
//  Purpose  : Bank of WIDTH independent 2-input NOR lanes with a
//             combinational output, a valid-qualified register stage and a
//             registered all-lanes-high flag.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             a, b            - operands, one bit per lane
//             in_valid        - capture a/b into the register stage
//             y               - combinational ~(a | b)
//             y_q, out_valid  - registered result and its valid
//             all_low_q       - registered: every lane of result is 1
//             hit_cnt         - saturating count of accepted all-low samples
//  Config   : NOR_GATE_UNIT_STATS_EN enables the hit counter; when undefined
//             hit_cnt is tied to zero and no counter logic exists.
//  Revision : 1.0  initial release
// ============================================================================
module nor_gate_unit
    import nor_gate_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int CNT_W = C_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_low_q,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] w_y;
    logic             w_all_low;
    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic             r_all_low_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            nor_lane u_lane (
                .a (a[gi]),
                .b (b[gi]),
                .y (w_y[gi])
            );
        end
    endgenerate

    // Every NOR lane high means both operands were zero across the bank.
    assign w_all_low = &w_y;

    // Result and flag hold while idle; only the valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
            r_all_low_q <= 1'b0;
        end else if (in_valid) begin
            r_y_q       <= w_y;
            r_out_valid <= 1'b1;
            r_all_low_q <= w_all_low;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef NOR_GATE_UNIT_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;

    // Saturating count of accepted samples whose result is all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (in_valid && w_all_low && !(&r_hit_cnt)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_hit_cnt;
`else
    assign hit_cnt = '0;
`endif

    assign y         = w_y;
    assign y_q       = r_y_q;
    assign out_valid = r_out_valid;
    assign all_low_q = r_all_low_q;

endmodule : nor_gate_unit
`default_nettype wire

// File: tb/tb_nor_gate_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nor_gate_unit
//  Purpose  : Self-checking bench for nor_gate_unit. Three instances:
//             WIDTH=1, WIDTH=8 (default counter), WIDTH=1 with CNT_W=2.
//             Directed steps plus randomized traffic against a reference
//             model built from the lane truth table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nor_gate_unit;
    import nor_gate_pkg::*;

`ifdef NOR_GATE_UNIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic        a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic        y1, yq1, ov1, al1;
    hit_cnt_t    cnt1;
    // WIDTH=8 instance
    logic [7:0]  a8 = '0, b8 = '0;
    logic        v8 = 1'b0;
    logic [7:0]  y8, yq8;
    logic        ov8, al8;
    hit_cnt_t    cnt8;
    // WIDTH=1, CNT_W=2 instance
    logic        as_ = 1'b0, bs = 1'b0, vs = 1'b0;
    logic        ys, yqs, ovs, als;
    logic [1:0]  cnts;

    nor_gate_unit #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .all_low_q(al1), .hit_cnt(cnt1)
    );
    nor_gate_unit #(.WIDTH(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .y(y8), .y_q(yq8), .out_valid(ov8), .all_low_q(al8), .hit_cnt(cnt8)
    );
    nor_gate_unit #(.WIDTH(1), .CNT_W(2)) u_duts (
        .clk(clk), .rst(rst), .a(as_), .b(bs), .in_valid(vs),
        .y(ys), .y_q(yqs), .out_valid(ovs), .all_low_q(als), .hit_cnt(cnts)
    );

    int checks   = 0;
    int failures = 0;

    // Lane truth table: output 1 only when both inputs are 0.
    function automatic logic [7:0] nor_ref(input logic [7:0] x, input logic [7:0] z, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (x[i] == 1'b0) && (z[i] == 1'b0);
        return r;
    endfunction

    // ---------------- reference model of the register stage ----------------
    logic [7:0] m8_yq = '0;  logic m8_ov = 0, m8_al = 0;  int m8_cnt = 0;
    logic       m1_yq = 0;   logic m1_ov = 0, m1_al = 0;  int m1_cnt = 0;
    logic       ms_yq = 0;   logic ms_ov = 0, ms_al = 0;  int ms_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m8_yq <= '0; m8_ov <= 0; m8_al <= 0; m8_cnt <= 0;
            m1_yq <= 0;  m1_ov <= 0; m1_al <= 0; m1_cnt <= 0;
            ms_yq <= 0;  ms_ov <= 0; ms_al <= 0; ms_cnt <= 0;
        end else begin
            m8_ov <= v8;
            if (v8) begin
                m8_yq <= nor_ref(a8, b8, 8);
                m8_al <= (a8 == 8'h00) && (b8 == 8'h00);
                if (STATS && a8 == 8'h00 && b8 == 8'h00 && m8_cnt < 65535) m8_cnt <= m8_cnt + 1;
            end
            m1_ov <= v1;
            if (v1) begin
                m1_yq <= (a1 == 0) && (b1 == 0);
                m1_al <= (a1 == 0) && (b1 == 0);
                if (STATS && a1 == 0 && b1 == 0 && m1_cnt < 65535) m1_cnt <= m1_cnt + 1;
            end
            ms_ov <= vs;
            if (vs) begin
                ms_yq <= (as_ == 0) && (bs == 0);
                ms_al <= (as_ == 0) && (bs == 0);
                if (STATS && as_ == 0 && bs == 0 && ms_cnt < 3) ms_cnt <= ms_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb();
        check("y1",  32'(y1), 32'(nor_ref({7'b0, a1}, {7'b0, b1}, 1)));
        check("y8",  32'(y8), 32'(nor_ref(a8, b8, 8)));
        check("ys",  32'(ys), 32'(nor_ref({7'b0, as_}, {7'b0, bs}, 1)));
    endtask

    task automatic check_regs();
        check("yq8",  32'(yq8),  32'(m8_yq));
        check("ov8",  32'(ov8),  32'(m8_ov));
        check("al8",  32'(al8),  32'(m8_al));
        check("cnt8", 32'(cnt8), 32'(m8_cnt));
        check("yq1",  32'(yq1),  32'(m1_yq));
        check("ov1",  32'(ov1),  32'(m1_ov));
        check("al1",  32'(al1),  32'(m1_al));
        check("cnt1", 32'(cnt1), 32'(m1_cnt));
        check("yqs",  32'(yqs),  32'(ms_yq));
        check("ovs",  32'(ovs),  32'(ms_ov));
        check("als",  32'(als),  32'(ms_al));
        check("cnts", 32'(cnts), 32'(ms_cnt));
    endtask

    initial begin
        logic [3:0] tt;
        tt = 4'b0001; // expected y for ab = 00,01,10,11 at bit index {a,b}

        // ---- reset state ----
        rst = 1'b1;
        step();
        step();
        check("rst_yq8", 32'(yq8), 32'h0);
        check("rst_ov8", 32'(ov8), 32'h0);
        check("rst_al8", 32'(al8), 32'h0);
        check("rst_cnt8", 32'(cnt8), 32'h0);
        check("rst_cnts", 32'(cnts), 32'h0);
        rst = 1'b0;

        // ---- WIDTH=1 truth table, combinational ----
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #10;
            check("tt_y1", 32'(y1), 32'(tt[i]));
        end

        // ---- WIDTH=1 register stage ----
        step();
        a1 = 0; b1 = 0; v1 = 1;
        step();
        check("w1_yq", 32'(yq1), 32'h1);
        check("w1_ov", 32'(ov1), 32'h1);
        check("w1_al", 32'(al1), 32'h1);
        v1 = 0; a1 = 1;
        step();
        check("w1_ov_drop", 32'(ov1), 32'h0);
        check("w1_yq_hold", 32'(yq1), 32'h1);
        check("w1_al_hold", 32'(al1), 32'h1);

        // ---- WIDTH=8 directed ----
        a8 = 8'hF0; b8 = 8'h0C; v8 = 1;
        #1;
        check("w8_y_f0_0c", 32'(y8), 32'h03);
        step();
        check("w8_yq_03", 32'(yq8), 32'h03);
        check("w8_al_0",  32'(al8), 32'h0);
        a8 = 8'h00; b8 = 8'h00;
        #1;
        check("w8_y_ff", 32'(y8), 32'hFF);
        step();
        check("w8_yq_ff", 32'(yq8), 32'hFF);
        check("w8_al_1",  32'(al8), 32'h1);

        // ---- reset together with in_valid: reset wins ----
        rst = 1; a8 = 8'h5A; b8 = 8'h21; v8 = 1;
        step();
        check("rv_yq8", 32'(yq8), 32'h0);
        check("rv_ov8", 32'(ov8), 32'h0);
        check("rv_al8", 32'(al8), 32'h0);
        check("rv_y8",  32'(y8),  32'h84);
        rst = 0; v8 = 0;

        // ---- counter: 3 all-zero + 2 non-zero accepted samples ----
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            a8 = (i < 3) ? 8'h00 : 8'h01;
            b8 = 8'h00;
            v8 = 1;
            as_ = 0; bs = 0; vs = 1;   // five all-zero samples into CNT_W=2
            step();
        end
        v8 = 0; vs = 0;
        step();
        check("cnt8_3",   32'(cnt8), STATS ? 32'd3 : 32'd0);
        check("cnts_sat", 32'(cnts), STATS ? 32'd3 : 32'd0);
        check_regs();
        rst = 1;
        step();
        check("cnt8_clr", 32'(cnt8), 32'h0);
        check("cnts_clr", 32'(cnts), 32'h0);
        rst = 0;

        // ---- randomized traffic with occasional mid-stream reset ----
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 24) == 0);
            a8  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            b8  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            v8  = ($urandom_range(0, 3) != 0);
            a1  = 1'($urandom);  b1 = 1'($urandom);  v1 = 1'($urandom);
            as_ = ($urandom_range(0, 2) == 0); bs = ($urandom_range(0, 2) == 0);
            vs  = ($urandom_range(0, 3) != 0);
            #1;
            check_comb();
            step();
            check_regs();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nor_gate_unit
`default_nettype wire

// File: doc/nor_gate_unit.md
Name: nor_gate_unit

Overview:
- Parameterised bank of WIDTH independent 2-input NOR lanes: y[i] = ~(a[i] | b[i]).
- Provides a purely combinational output for truth-table checks.
- Also provides a registered, valid-qualified output for pipelined use in the datapath.
- Includes an all-lanes reduction flag, so the block serves as a reusable basic-logic primitive.

Parameters:
- WIDTH, 1, number of independent NOR lanes (≥1).
- CNT_W, 16, width of the optional statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies a/b for capture into the register stage.
- y  output  WIDTH  combinational NOR of a and b, ~(a|b).
- y_q  output  WIDTH  registered NOR result.
- out_valid  output  1  y_q holds a valid result.
- all_low_q  output  1  registered flag: every lane of the captured result is 1, i.e. all inputs were 0.
- hit_cnt  output  CNT_W  optional-feature counter (see below).

Behaviour:
- One clock; reset is synchronous and active-high.
- y is purely combinational: y = ~(a | b) bitwise, zero latency.
  - No dependence on clk or rst.
  - y is valid whenever a and b are known.
- Truth table per lane:
  - 00 -> 1
  - 01 -> 0
  - 10 -> 0
  - 11 -> 0
- Register stage, on each rising clk edge:
  - If rst: y_q = 0, out_valid = 0, all_low_q = 0.
  - Else if in_valid: y_q = ~(a|b); out_valid = 1; all_low_q = &(~(a|b)).
  - Else: y_q and all_low_q hold; out_valid = 0.
- Latency from in_valid to out_valid: exactly 1 cycle. Throughput: one result per cycle. No backpressure.
- rst asserted together with in_valid: reset wins; the sample is dropped.
- Reset mid-stream clears all registers on that edge. y keeps tracking the inputs throughout.
- X on a or b propagates to y. Registered outputs are defined only after the first reset.

Optional Feature:
- Macro: NOR_GATE_UNIT_STATS_EN.
- Defined:
  - hit_cnt counts the accepted samples (in_valid=1, rst=0) whose result has all_low = 1.
  - Increments by 1 per such cycle and saturates at all-ones.
  - Cleared to 0 by rst.
- Not defined: hit_cnt is tied to 0 and no counter logic is instantiated. The port is always present.

Decomposition:
- Package nor_gate_pkg holds:
  - the default WIDTH (1) and CNT_W (16) constants;
  - a typedef for the saturating counter type.
- Sub-module nor_lane: single-bit combinational 2-input NOR (a, b -> y), instantiated WIDTH times by a generate loop.
- Register stage, reduction and counter live in the top module.

Test Plan:
- WIDTH=1, apply a,b = 00, 01, 10, 11, 10 time units apart -> y = 1, 0, 0, 0 respectively, checked after settling.
- WIDTH=1, in_valid=1 with a=0, b=0 at cycle N -> at cycle N+1: y_q=1, out_valid=1, all_low_q=1. in_valid=0 next cycle -> out_valid=0, y_q holds 1.
- WIDTH=8:
  - a=8'hF0, b=8'h0C, in_valid=1 -> y=8'h03 immediately; y_q=8'h03 and all_low_q=0 one cycle later.
  - a=b=8'h00 -> y=8'hFF, all_low_q=1.
- Reset: after valid traffic, assert rst together with in_valid=1 -> next edge y_q=0, out_valid=0, all_low_q=0; y still equals ~(a|b).
- With NOR_GATE_UNIT_STATS_EN:
  - 3 accepted all-zero samples and 2 non-zero samples -> hit_cnt=3.
  - CNT_W=2 with 5 all-zero samples -> hit_cnt saturates at 3.
  - rst -> hit_cnt=0.
  - Without the macro, hit_cnt stays 0 throughout.
